// File: rtl/mem_pkg.sv
// Shared types and constants for the 16x32 single-port storage array.
// The parity helper is only referenced when MEM_PARITY_EN is defined.
package mem_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input data_t word);
    return ^word;
  endfunction

endpackage

// File: rtl/mem_parity_gen.sv
// Combinational even-parity generator for one data word.
module mem_parity_gen
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  assign parity = even_parity(data);

endmodule

// File: rtl/mem_array_16x32.sv
// Single-port 16x32 storage array with registered read data and valid.
// Optional per-word parity with error injection when MEM_PARITY_EN is defined.
module mem_array_16x32
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out
`ifdef MEM_PARITY_EN
  ,
  input  logic              par_flip,
  output logic              parity_err
`endif
);

  data_t mem_r [DEPTH];
  data_t data_out_r;
  logic  valid_r;
  data_t rd_word_s;
  op_t   op_s;
  logic  rd_s;
  logic  wr_s;

  assign rd_word_s = mem_r[addr];

  // Decode the request into a read or write strobe.
  always_comb begin
    op_s = OP_READ;
    rd_s = 1'b0;
    wr_s = 1'b0;
    if (wr_en) begin
      op_s = OP_WRITE;
    end else begin
      op_s = OP_READ;
    end
    if (en) begin
      case (op_s)
        OP_WRITE: wr_s = 1'b1;
        OP_READ:  rd_s = 1'b1;
        default: begin
          rd_s = 1'b0;
          wr_s = 1'b0;
        end
      endcase
    end else begin
      rd_s = 1'b0;
      wr_s = 1'b0;
    end
  end

  // Storage array; reset clears every word so no partial write survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_s) begin
      mem_r[addr] <= data_in;
    end
  end

  // Read data register holds its value across writes and idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_r <= {DATA_W{1'b0}};
      valid_r    <= 1'b0;
    end else begin
      valid_r <= rd_s;
      if (rd_s) begin
        data_out_r <= rd_word_s;
      end
    end
  end

  assign data_out  = data_out_r;
  assign valid_out = valid_r;

`ifdef MEM_PARITY_EN
  logic par_r [DEPTH];
  logic par_err_r;
  logic wr_par_s;
  logic rd_par_s;

  mem_parity_gen u_wr_par (
    .data   (data_in),
    .parity (wr_par_s)
  );

  mem_parity_gen u_rd_par (
    .data   (rd_word_s),
    .parity (rd_par_s)
  );

  // Stored parity bits; par_flip inverts the bit to inject an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_r[i] <= 1'b0;
      end
    end else if (wr_s) begin
      par_r[addr] <= wr_par_s ^ par_flip;
    end
  end

  // Parity error is qualified by the read and cleared on any non-read cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_r <= 1'b0;
    end else if (rd_s) begin
      par_err_r <= rd_par_s ^ par_r[addr];
    end else begin
      par_err_r <= 1'b0;
    end
  end

  assign parity_err = par_err_r;
`endif

endmodule

// File: tb/tb_mem_array_16x32.sv
// Randomized scoreboard bench for mem_array_16x32 (build with or without MEM_PARITY_EN).
module tb_mem_array_16x32;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        wr_en;
  logic [3:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        valid_out;
`ifdef MEM_PARITY_EN
  logic        par_flip;
  logic        parity_err;
`endif

  typedef struct {
    logic [31:0] data;
    logic        perr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [16];
  logic        model_flip [16];
  int          passed;
  int          total;

  mem_array_16x32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr_en      (wr_en),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out)
`ifdef MEM_PARITY_EN
    ,
    .par_flip   (par_flip),
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      model_mem[i]  = 32'h0;
      model_flip[i] = 1'b0;
    end
  endtask

  // Drive one request at the falling edge and record its expected outcome.
  task automatic issue(input logic e, input logic w, input logic [3:0] a,
                       input logic [31:0] d, input logic f);
    exp_t item;
    @(negedge clk);
    en      = e;
    wr_en   = w;
    addr    = a;
    data_in = d;
`ifdef MEM_PARITY_EN
    par_flip = f;
`endif
    if (e && w) begin
      model_mem[a]  = d;
      model_flip[a] = f;
    end else if (e) begin
      item.data = model_mem[a];
      item.perr = model_flip[a];
      exp_q.push_back(item);
    end
  endtask

  // Monitor: every valid cycle must match the oldest outstanding read.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", {31'h0, valid_out}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", data_out, e.data);
`ifdef MEM_PARITY_EN
          check("parity_err", {31'h0, parity_err}, {31'h0, e.perr});
`endif
        end
      end else begin
`ifdef MEM_PARITY_EN
        check("parity_idle", {31'h0, parity_err}, 32'h0);
`endif
      end
    end
  end

  initial begin
    passed  = 0;
    total   = 0;
    rst_n   = 1'b0;
    en      = 1'b0;
    wr_en   = 1'b0;
    addr    = 4'h0;
    data_in = 32'h0;
`ifdef MEM_PARITY_EN
    par_flip = 1'b0;
`endif
    model_clear();
    #12;
    check("reset_valid", {31'h0, valid_out}, 32'h0);
    check("reset_data", data_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // All words read back as zero after reset.
    for (int i = 0; i < 16; i++) issue(1'b1, 1'b0, i[3:0], 32'h0, 1'b0);

    // Write then read the same address; the write cycle itself is not valid.
    issue(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 1'b0, 4'd3, 32'h0, 1'b0);
    check("write_no_valid", {31'h0, valid_out}, 32'h0);

    // Boundary addresses, back-to-back reads.
    issue(1'b1, 1'b1, 4'd0, 32'h00000001, 1'b0);
    issue(1'b1, 1'b1, 4'd15, 32'hFFFFFFFF, 1'b0);
    issue(1'b1, 1'b0, 4'd0, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 4'd15, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 4'd3, 32'h0, 1'b0);

    // Idle cycles drop valid and hold the last read data; X inputs are ignored.
    issue(1'b0, 1'b0, 4'hx, 32'hxxxxxxxx, 1'b0);
    issue(1'b0, 1'b1, 4'hx, 32'hxxxxxxxx, 1'b0);
    check("idle_valid", {31'h0, valid_out}, 32'h0);
    check("idle_hold", data_out, 32'hDEADBEEF);
    @(negedge clk);
    check("idle_valid2", {31'h0, valid_out}, 32'h0);
    check("idle_hold2", data_out, 32'hDEADBEEF);

    // Asynchronous reset while a read result is being presented.
    issue(1'b1, 1'b1, 4'd7, 32'hA5A5A5A5, 1'b0);
    issue(1'b1, 1'b0, 4'd7, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    check("pre_reset_valid", {31'h0, valid_out}, 32'h1);
    check("pre_reset_data", data_out, 32'hA5A5A5A5);
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check("async_reset_valid", {31'h0, valid_out}, 32'h0);
    check("async_reset_data", data_out, 32'h0);
    exp_q.delete();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 1'b0, 4'd7, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 4'd3, 32'h0, 1'b0);

`ifdef MEM_PARITY_EN
    // Injected parity error is reported, and clears after a clean rewrite.
    issue(1'b1, 1'b1, 4'd5, 32'h00000001, 1'b1);
    issue(1'b1, 1'b0, 4'd5, 32'h0, 1'b0);
    issue(1'b1, 1'b1, 4'd5, 32'h00000001, 1'b0);
    issue(1'b1, 1'b0, 4'd5, 32'h0, 1'b0);
`endif

    // Randomized traffic against the array model.
    for (int n = 0; n < 400; n++) begin
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 7) == 0);
    end

    issue(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    issue(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("queue_drain", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_array_16x32.md
Name: mem_array_16x32

Overview:
- Synchronous single-port storage array: 16 words x 32 bits, one access per clock (read or write).
- Sits behind the MEM_IF bundle (clk carried in the interface) and is the DUT of the class-based memory environment.
- Requests are driven by the environment driver; read data is captured by the monitor/scoreboard, qualified by valid_out.

Parameters:
- DEPTH, 16, number of words.
- ADDR_W, 4, address width (log2 DEPTH).
- DATA_W, 32, word width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  access request; ignored when 0.
- wr_en  input  1  1 = write, 0 = read (only meaningful with en=1).
- addr  input  ADDR_W  word address 0..15.
- data_in  input  DATA_W  write data.
- data_out  output  DATA_W  registered read data.
- valid_out  output  1  high for exactly the cycle data_out carries a fresh read result.
- parity_err  output  1  present only with MEM_PARITY_EN (see below).
- par_flip  input  1  present only with MEM_PARITY_EN (see below).

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - All 16 words cleared to 32'h0.
  - data_out=0, valid_out=0, parity_err=0.
  - Reset mid-access aborts the access; no partial write survives.
- Write: en=1, wr_en=1 at posedge -> mem[addr]<=data_in.
  - valid_out=0 next cycle; data_out holds its previous value.
- Read: en=1, wr_en=0 at posedge -> data_out<=mem[addr] and valid_out<=1.
  - Latency is one cycle: result is visible after the same edge that sampled the request.
- Idle: en=0 -> valid_out<=0, data_out holds, memory unchanged.
- Back-to-back reads: valid_out stays high continuously; data_out updates every cycle.
- Write then read of the same address on the next cycle returns the newly written data.
- No same-cycle read/write conflict exists (single port, wr_en selects the operation).
- addr covers the full range; no out-of-range case exists. Addresses 0 and 15 behave identically to all others.
- Inputs sampled at posedge only; X on addr/data_in while en=0 has no effect.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from data_in on write.
  - If par_flip=1 during a write, the stored parity bit is inverted (error injection).
  - On a read, parity_err is registered alongside data_out: 1 if the recomputed parity mismatches the stored bit, else 0. It is valid with valid_out and is 0 when valid_out=0.
  - Reset clears all parity bits to 0, which is consistent with the zeroed data.
- Undefined:
  - par_flip and parity_err ports are absent and no parity storage exists.
  - All other behaviour is identical.

Decomposition:
- Package mem_pkg:
  - DEPTH, ADDR_W, DATA_W localparams.
  - typedef addr_t (logic [ADDR_W-1:0]).
  - typedef data_t (logic [DATA_W-1:0]).
  - typedef enum op_t {OP_READ, OP_WRITE}, shared with the environment transaction class.
- One natural sub-module: mem_parity_gen (combinational XOR-reduce of a data_t), instantiated on the write path and the read path only under MEM_PARITY_EN.
- Storage array and output registers stay in the top module.

Test Plan:
- Reset then read all 16 addresses -> data_out=32'h0 with valid_out=1 each cycle after its request.
- Write addr 3 = 32'hDEADBEEF, next cycle read addr 3 -> data_out=32'hDEADBEEF, valid_out=1 one cycle later. Write cycle itself gives valid_out=0.
- Write addr 0 = 32'h00000001 and addr 15 = 32'hFFFFFFFF, read both back-to-back -> two consecutive valid cycles returning those values; no aliasing between words.
- Read addr 3, then en=0 for 2 cycles -> valid_out drops to 0, data_out holds 32'hDEADBEEF.
- Write addr 7 = 32'hA5A5A5A5, assert rst_n=0 mid-cycle, release, read addr 7 -> 32'h0. During reset, valid_out=0 immediately, without waiting for a clock edge.
- MEM_PARITY_EN:
  - Write addr 5 = 32'h1 with par_flip=1, read addr 5 -> data_out=32'h1, parity_err=1.
  - Rewrite with par_flip=0 and read -> parity_err=0.
